// File: rtl/divider_4_bit_pkg.sv
// Shared constants for the 4-bit restoring divider.
//   WIDTH      : operand/result width in bits
//   ITER_COUNT : restoring steps per division (one per quotient bit)
//   St*        : FSM state encoding
package divider_4_bit_pkg;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned ITER_COUNT = WIDTH;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/divider_4_bit_subtractor_5_bit.sv
// Ripple-carry subtractor used for the divider's trial subtraction.
// Computes a - b as a + ~b + 1 through a chain of full adders.
//   a_i      : minuend
//   b_i      : subtrahend
//   diff_o   : a - b (modulo 2^Width)
//   borrow_o : high when b > a (inverse of the final carry out)
module subtractor_5_bit #(
  parameter int unsigned Width = 5
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             borrow_o
);

  logic [Width-1:0] b_n;
  logic             carry;

  assign b_n = ~b_i;

  always_comb begin
    diff_o = '0;
    carry  = 1'b1;
    for (int i = 0; i < Width; i++) begin
      diff_o[i] = a_i[i] ^ b_n[i] ^ carry;
      carry     = (a_i[i] & b_n[i]) | (carry & (a_i[i] ^ b_n[i]));
    end
    borrow_o = ~carry;
  end

endmodule

// File: rtl/divider_4_bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, reset    : clock and asynchronous active-high reset
//   start         : request a division (ignored while busy)
//   dividend      : numerator, captured with start
//   divisor       : denominator, captured with start
//   busy          : division in progress
//   done          : one-cycle pulse, results valid
//   quotient      : result quotient (held until next accepted start)
//   remainder     : result remainder (held until next accepted start)
//   div_by_zero   : captured divisor was zero
module divider_4_bit #(
  parameter int unsigned WIDTH = divider_4_bit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import divider_4_bit_pkg::*;

  localparam int unsigned CntW    = (ITER_COUNT > 1) ? $clog2(ITER_COUNT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ITER_COUNT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend, shifted out MSB-first
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;    // partial remainder, one bit wider than operands
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_borrow;

  // Shift partial remainder left and bring in the next dividend bit.
  assign trial_a = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
  assign trial_b = {1'b0, dvs_q};

  subtractor_5_bit #(
    .Width (WIDTH + 1)
  ) u_sub (
    .a_i      (trial_a),
    .b_i      (trial_b),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back divisions.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (divisor == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            dvd_d   = dividend;
            dvs_d   = divisor;
            quo_d   = '0;
            rem_d   = '0;
            cnt_d   = CntLoad;
            dbz_d   = 1'b0;
          end
        end
      end

      StRun: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};
        // Restoring step: keep the shifted value when the subtraction went negative.
        rem_d = trial_borrow ? trial_a : trial_diff;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_4_bit.md
DIVIDER_4_BIT -- requirements
Module: divider_4_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand and result width in bits; only 4 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only when busy=0.
REQ-005 The block SHALL have port dividend, input, 4 bits: unsigned numerator, captured with start.
REQ-006 The block SHALL have port divisor, input, 4 bits: unsigned denominator, captured with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking results valid.
REQ-009 The block SHALL have port quotient, output, 4 bits: unsigned quotient result.
REQ-010 The block SHALL have port remainder, output, 4 bits: unsigned remainder result.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with results when the captured divisor was 0.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 IDLE SHALL go to RUN on an edge with start=1 and divisor!=0, capturing the operands, clearing the 5-bit partial remainder, loading an iteration counter with 3 and setting busy=1.
REQ-014 IDLE SHALL go to DONE on an edge with start=1 and divisor=0: quotient=4'hF, remainder=dividend, div_by_zero=1, busy=0, RUN skipped.
REQ-015 Each RUN edge SHALL perform one restoring step, MSB-first: shift the partial remainder left, bringing in the next dividend bit, then subtract the zero-extended divisor (5-bit).
REQ-016 In each RUN step, a non-negative difference SHALL replace the partial remainder with quotient bit 1; a negative difference SHALL leave it unchanged with quotient bit 0.
REQ-017 RUN SHALL last exactly 4 edges; on the 4th edge it SHALL go to DONE with final quotient/remainder on the outputs, busy=0 and div_by_zero=0.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE; a start present in the DONE cycle SHALL be accepted as in IDLE.
REQ-019 Latency SHALL be: done high in the 5th cycle after the start edge for a normal division, and in the cycle after the start edge for divide-by-zero.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands or progress.
REQ-021 quotient, remainder and div_by_zero SHALL hold their last values until the next accepted start; quotient and remainder are intermediate (not valid) while busy=1.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every nonzero divisor.
REQ-023 Operands changing after the start edge SHALL NOT affect the result.

Reset
REQ-024 reset=1 SHALL immediately force state IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, independent of clk.
REQ-025 Reset mid-RUN SHALL abandon the division; no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-027 A shared package SHALL hold WIDTH, the state encoding (IDLE, RUN, DONE) and the iteration count constant (WIDTH).
REQ-028 The trial subtraction SHALL be one sub-module, subtractor_5_bit (a - b via full adders with inverted b and carry_in=1; borrow = not carry_out), instantiated once.

Verification
REQ-029 dividend=13, divisor=3, start one cycle -> busy for 4 cycles, done pulse 5th cycle, quotient=4, remainder=1, div_by_zero=0.
REQ-030 15/1 -> quotient=15, remainder=0; 2/7 -> quotient=0, remainder=2; 0/5 -> quotient=0, remainder=0.
REQ-031 9/0 -> done the cycle after start, quotient=4'hF, remainder=9, div_by_zero=1, busy never high.
REQ-032 start 12/5, then start 7/7 and operand changes during busy -> single done with quotient=2, remainder=2.
REQ-033 reset pulsed in 2nd RUN cycle of 14/3 -> outputs all 0 immediately, no done; next start 14/3 -> quotient=4, remainder=2.
REQ-034 start held high from the done cycle of 10/4 (quotient=2, remainder=2) with new operands 11/2 -> second division accepted without an idle gap, quotient=5, remainder=1; exhaustive sweep of all 256 operand pairs checks REQ-022.
